trap_csr_ctrl: RTL and testbench

//  Machine-mode CSR file and trap sequencer, directly downstream of the exception verifier.

---
 rtl/trap_csr_ctrl.sv | 179 +++++++++++++++++
 tb/tb_trap_csr_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_csr_ctrl.sv
// trap_csr_ctrl
//   Machine-mode CSR file and trap sequencer sitting downstream of the
//   exception verifier. Holds mstatus, mtvec, mepc, mcause and mip, feeds
//   csr_info back to the verifier, sequences trap entry (save state, redirect
//   to mtvec, flush) and uret (restore mstatus, redirect to mepc), and serves
//   csrrw/csrrwi accesses from the datapath.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   exception, excep_info trap request from the verifier and its payload
//                         {cause_type[31], mcause[30:24], mstatus_new[23:16], mret[15:0]}
//   irq_ext               level external interrupt, sets mip[0] (sticky)
//   uret                  decoded uret in execute, acted on only in the handler
//   csr_we, csr_addr,
//   csr_wdata             CSR write port; csr_rdata is a combinational read
//   csr_info              {mip[15:0], mstatus[15:0]} to the verifier
//   stall, flush,
//   pc_sel_trap, pc_trap  pipeline control and PC redirect, decoded from state
//   in_handler            high while the trap handler runs
module trap_csr_ctrl #(
  parameter int unsigned         ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]   MTVEC_RST = 16'h0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exception,
  input  logic [31:0]       excep_info,
  input  logic              irq_ext,
  input  logic              uret,
  input  logic              csr_we,
  input  logic [11:0]       csr_addr,
  input  logic [31:0]       csr_wdata,
  output logic [31:0]       csr_rdata,
  output logic [31:0]       csr_info,
  output logic              stall,
  output logic              flush,
  output logic              pc_sel_trap,
  output logic [ADDR_W-1:0] pc_trap,
  output logic              in_handler
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  localparam logic [31:0] MTVEC_RST_W = 32'(MTVEC_RST) & ~32'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_REDIR,
    S_HANDLER,
    S_RET
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] info_q, info_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mip_q, mip_d;
  logic        we_ok;

  always_comb begin
    state_d   = state_q;
    info_d    = info_q;
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mip_d     = mip_q;

    // The pipeline is frozen or being flushed in SAVE/REDIR, so any write
    // strobe seen there belongs to a killed instruction.
    we_ok = csr_we && (state_q != S_SAVE) && (state_q != S_REDIR);

    if (we_ok) begin
      case (csr_addr)
        A_MSTATUS: mstatus_d = csr_wdata;
        A_MTVEC:   mtvec_d   = {csr_wdata[31:2], 2'b00};
        A_MEPC:    mepc_d    = csr_wdata;
        A_MCAUSE:  mcause_d  = csr_wdata;
        A_MIP:     mip_d     = csr_wdata;
        default:   ;
      endcase
    end

    // Trap-sequence updates come after the CSR write so they take priority.
    case (state_q)
      S_IDLE: begin
        if (exception) begin
          info_d  = excep_info;
          state_d = S_SAVE;
        end
      end
      S_SAVE: begin
        mepc_d    = 32'(info_q[ADDR_W-1:0]);
        mcause_d  = {info_q[31], 24'b0, info_q[30:24]};
        mstatus_d = {24'b0, info_q[23:16]};
        if (info_q[31]) begin
          mip_d[0] = 1'b0;
        end
        state_d = S_REDIR;
      end
      S_REDIR: begin
        state_d = S_HANDLER;
      end
      S_HANDLER: begin
        if (uret) begin
          state_d = S_RET;
        end
      end
      S_RET: begin
        mstatus_d = 32'h1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new interrupt request beats any clear in the same cycle.
    if (irq_ext) begin
      mip_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      info_q    <= '0;
      mstatus_q <= 32'h1;
      mtvec_q   <= MTVEC_RST_W;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mip_q     <= '0;
    end else begin
      state_q   <= state_d;
      info_q    <= info_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mip_q     <= mip_d;
    end
  end

  // Moore outputs: all pipeline controls follow the state register only, so
  // an asynchronous reset drops them in the same instant.
  always_comb begin
    stall       = (state_q == S_SAVE);
    flush       = (state_q == S_REDIR) || (state_q == S_RET);
    pc_sel_trap = flush;
    in_handler  = (state_q == S_HANDLER);
    pc_trap     = '0;
    if (state_q == S_REDIR) begin
      pc_trap = mtvec_q[ADDR_W-1:0];
    end else if (state_q == S_RET) begin
      pc_trap = mepc_q[ADDR_W-1:0];
    end
  end

  always_comb begin
    case (csr_addr)
      A_MSTATUS: csr_rdata = mstatus_q;
      A_MTVEC:   csr_rdata = mtvec_q;
      A_MEPC:    csr_rdata = mepc_q;
      A_MCAUSE:  csr_rdata = mcause_q;
      A_MIP:     csr_rdata = mip_q;
      default:   csr_rdata = '0;
    endcase
  end

  assign csr_info = {mip_q[15:0], mstatus_q[15:0]};

endmodule

// File: tb/tb_trap_csr_ctrl.sv
module tb_trap_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exception;
  logic [31:0] excep_info;
  logic        irq_ext;
  logic        uret;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] csr_info;
  logic        stall;
  logic        flush;
  logic        pc_sel_trap;
  logic [15:0] pc_trap;
  logic        in_handler;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // {stall, flush, pc_sel_trap, in_handler, pc_trap}
  logic [19:0] ctl;
  assign ctl = {stall, flush, pc_sel_trap, in_handler, pc_trap};

  always #5 clk = ~clk;

  trap_csr_ctrl #(
    .ADDR_W    (16),
    .MTVEC_RST (16'h0100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exception   (exception),
    .excep_info  (excep_info),
    .irq_ext     (irq_ext),
    .uret        (uret),
    .csr_we      (csr_we),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_info    (csr_info),
    .stall       (stall),
    .flush       (flush),
    .pc_sel_trap (pc_sel_trap),
    .pc_trap     (pc_trap),
    .in_handler  (in_handler)
  );

  // ------------------------------------------------------------------
  // Reference model: CSR values plus a queue of pending pipeline events.
  // An accepted exception schedules "save" then "redirect to mtvec";
  // uret inside the handler schedules "redirect to mepc".
  // ------------------------------------------------------------------
  typedef enum int {EV_SAVE, EV_TRAP_REDIR, EV_RET_REDIR} ev_e;

  ev_e         sched[$];
  bit          m_handler;
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mip, m_info;

  function automatic void model_reset();
    sched.delete();
    m_handler = 1'b0;
    m_mstatus = 32'h1;
    m_mtvec   = 32'h100;
    m_mepc    = 32'h0;
    m_mcause  = 32'h0;
    m_mip     = 32'h0;
    m_info    = 32'h0;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [19:0] model_ctl();
    if (sched.size() == 0) return {3'b000, m_handler, 16'h0};
    case (sched[0])
      EV_SAVE:       return {4'b1000, 16'h0};
      EV_TRAP_REDIR: return {4'b0110, m_mtvec[15:0]};
      default:       return {4'b0110, m_mepc[15:0]};
    endcase
  endfunction

  function automatic void model_step(input bit exc, input logic [31:0] info,
                                     input bit irq, input bit ur, input bit we,
                                     input logic [11:0] a, input logic [31:0] wd);
    bit  has;
    ev_e cur;
    has = (sched.size() != 0);
    cur = has ? sched[0] : EV_SAVE;
    if (we && !(has && (cur == EV_SAVE || cur == EV_TRAP_REDIR))) begin
      case (a)
        12'h300: m_mstatus = wd;
        12'h305: m_mtvec   = wd & ~32'h3;
        12'h341: m_mepc    = wd;
        12'h342: m_mcause  = wd;
        12'h344: m_mip     = wd;
        default: ;
      endcase
    end
    if (has && cur == EV_SAVE) begin
      m_mepc    = {16'h0, m_info[15:0]};
      m_mcause  = {m_info[31], 24'h0, m_info[30:24]};
      m_mstatus = {24'h0, m_info[23:16]};
      if (m_info[31]) m_mip[0] = 1'b0;
    end
    if (has && cur == EV_RET_REDIR) m_mstatus = 32'h1;
    if (irq) m_mip[0] = 1'b1;
    if (has) begin
      void'(sched.pop_front());
      if (cur == EV_TRAP_REDIR) m_handler = 1'b1;
    end else if (!m_handler && exc) begin
      m_info = info;
      sched.push_back(EV_SAVE);
      sched.push_back(EV_TRAP_REDIR);
    end else if (m_handler && ur) begin
      m_handler = 1'b0;
      sched.push_back(EV_RET_REDIR);
    end
  endfunction

  task automatic idle_inputs();
    exception  = 1'b0;
    excep_info = 32'h0;
    irq_ext    = 1'b0;
    uret       = 1'b0;
    csr_we     = 1'b0;
    csr_addr   = 12'h0;
    csr_wdata  = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ctl !== 20'h0) begin
      n_bad++; $display("FAIL reset_ctl_during: got %h want %h", ctl, 20'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (csr_info !== 32'h0000_0001) begin
      n_bad++; $display("FAIL reset_csr_info: got %h want %h", csr_info, 32'h1);
    end
    csr_addr = 12'h305; #1;
    n_cmp++;
    if (csr_rdata !== 32'h100) begin
      n_bad++; $display("FAIL reset_mtvec: got %h want %h", csr_rdata, 32'h100);
    end
    n_cmp++;
    if (ctl !== 20'h0) begin
      n_bad++; $display("FAIL reset_ctl_after: got %h want %h", ctl, 20'h0);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    exception = 1'b1; excep_info = 32'h0210_0040;
    @(negedge clk);
    exception = 1'b0; excep_info = 32'h0;
    n_cmp++;
    if (ctl !== {4'b1000, 16'h0}) begin
      n_bad++; $display("FAIL illegal_stall: got %h want %h", ctl, {4'b1000, 16'h0});
    end
    @(negedge clk);
    n_cmp++;
    if (ctl !== {4'b0110, 16'h0100}) begin
      n_bad++; $display("FAIL illegal_redirect: got %h want %h", ctl, {4'b0110, 16'h0100});
    end
    csr_addr = 12'h341; #1;
    n_cmp++;
    if (csr_rdata !== 32'h40) begin
      n_bad++; $display("FAIL illegal_mepc: got %h want %h", csr_rdata, 32'h40);
    end
    csr_addr = 12'h342; #1;
    n_cmp++;
    if (csr_rdata !== 32'h2) begin
      n_bad++; $display("FAIL illegal_mcause: got %h want %h", csr_rdata, 32'h2);
    end
    n_cmp++;
    if (csr_info[15:0] !== 16'h0010) begin
      n_bad++; $display("FAIL illegal_mstatus: got %h want %h", csr_info[15:0], 16'h0010);
    end
    @(negedge clk);
    n_cmp++;
    if (ctl !== {4'b0001, 16'h0}) begin
      n_bad++; $display("FAIL illegal_in_handler: got %h want %h", ctl, {4'b0001, 16'h0});
    end
  endtask

  task automatic test_return();
    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h44;
    @(negedge clk);
    csr_we = 1'b0; #1;
    n_cmp++;
    if (csr_rdata !== 32'h44) begin
      n_bad++; $display("FAIL return_mepc_write: got %h want %h", csr_rdata, 32'h44);
    end
    uret = 1'b1;
    @(negedge clk);
    uret = 1'b0;
    n_cmp++;
    if (ctl !== {4'b0110, 16'h0044}) begin
      n_bad++; $display("FAIL return_redirect: got %h want %h", ctl, {4'b0110, 16'h0044});
    end
    @(negedge clk);
    n_cmp++;
    if (ctl !== 20'h0) begin
      n_bad++; $display("FAIL return_idle: got %h want %h", ctl, 20'h0);
    end
    csr_addr = 12'h300; #1;
    n_cmp++;
    if (csr_rdata !== 32'h1) begin
      n_bad++; $display("FAIL return_mstatus: got %h want %h", csr_rdata, 32'h1);
    end
    // uret outside the handler must not redirect
    uret = 1'b1;
    @(negedge clk);
    uret = 1'b0;
    n_cmp++;
    if (ctl !== 20'h0) begin
      n_bad++; $display("FAIL uret_in_idle: got %h want %h", ctl, 20'h0);
    end
  endtask

  task automatic test_interrupt();
    irq_ext = 1'b1;
    @(negedge clk);
    irq_ext = 1'b0;
    n_cmp++;
    if (csr_info !== 32'h0001_0001) begin
      n_bad++; $display("FAIL irq_pending: got %h want %h", csr_info, 32'h0001_0001);
    end
    exception = 1'b1; excep_info = 32'h9010_0080;
    @(negedge clk);
    exception = 1'b0; excep_info = 32'h0;
    n_cmp++;
    if (ctl !== {4'b1000, 16'h0}) begin
      n_bad++; $display("FAIL irq_stall: got %h want %h", ctl, {4'b1000, 16'h0});
    end
    @(negedge clk);
    csr_addr = 12'h342; #1;
    n_cmp++;
    if (csr_rdata !== 32'h8000_0010) begin
      n_bad++; $display("FAIL irq_mcause: got %h want %h", csr_rdata, 32'h8000_0010);
    end
    n_cmp++;
    if (csr_info !== 32'h0000_0010) begin
      n_bad++; $display("FAIL irq_mip_cleared: got %h want %h", csr_info, 32'h0000_0010);
    end
    @(negedge clk);
  endtask

  task automatic test_conflicts();
    // in the handler: exceptions are ignored
    exception = 1'b1; excep_info = 32'h0520_1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ctl !== {4'b0001, 16'h0}) begin
        n_bad++; $display("FAIL handler_ignores_exc: got %h want %h", ctl, {4'b0001, 16'h0});
      end
    end
    exception = 1'b0; excep_info = 32'h0;
    csr_addr = 12'h341; #1;
    n_cmp++;
    if (csr_rdata !== 32'h80) begin
      n_bad++; $display("FAIL handler_mepc_kept: got %h want %h", csr_rdata, 32'h80);
    end
    uret = 1'b1;
    @(negedge clk);
    uret = 1'b0;
    @(negedge clk);
    // set beats a CSR-write clear of mip[0]
    irq_ext = 1'b1; csr_we = 1'b1; csr_addr = 12'h344; csr_wdata = 32'h0;
    @(negedge clk);
    irq_ext = 1'b0; csr_we = 1'b0; #1;
    n_cmp++;
    if (csr_rdata !== 32'h1) begin
      n_bad++; $display("FAIL mip_set_beats_write: got %h want %h", csr_rdata, 32'h1);
    end
    // exception and uret together in idle: exception wins;
    // irq_ext in the SAVE cycle keeps mip[0] set
    exception = 1'b1; uret = 1'b1; excep_info = 32'h9010_0080;
    @(negedge clk);
    exception = 1'b0; uret = 1'b0; excep_info = 32'h0; irq_ext = 1'b1;
    n_cmp++;
    if (ctl !== {4'b1000, 16'h0}) begin
      n_bad++; $display("FAIL exc_beats_uret: got %h want %h", ctl, {4'b1000, 16'h0});
    end
    @(negedge clk);
    irq_ext = 1'b0; #1;
    n_cmp++;
    if (csr_rdata !== 32'h1) begin
      n_bad++; $display("FAIL mip_irq_during_save: got %h want %h", csr_rdata, 32'h1);
    end
    @(negedge clk);
    uret = 1'b1;
    @(negedge clk);
    uret = 1'b0;
    n_cmp++;
    if (ctl !== {4'b0110, 16'h0080}) begin
      n_bad++; $display("FAIL conflict_return: got %h want %h", ctl, {4'b0110, 16'h0080});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 32'h0000_0203;
    @(negedge clk);
    csr_we = 1'b0; #1;
    n_cmp++;
    if (csr_rdata !== 32'h200) begin
      n_bad++; $display("FAIL mtvec_low_bits: got %h want %h", csr_rdata, 32'h200);
    end
    exception = 1'b1; excep_info = 32'h0210_0040;
    @(negedge clk);
    exception = 1'b0; excep_info = 32'h0;
    @(negedge clk);
    n_cmp++;
    if (ctl !== {4'b0110, 16'h0200}) begin
      n_bad++; $display("FAIL redirect_new_mtvec: got %h want %h", ctl, {4'b0110, 16'h0200});
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if (ctl !== 20'h0) begin
      n_bad++; $display("FAIL midreset_ctl: got %h want %h", ctl, 20'h0);
    end
    n_cmp++;
    if (csr_info !== 32'h0000_0001) begin
      n_bad++; $display("FAIL midreset_csr_info: got %h want %h", csr_info, 32'h1);
    end
    n_cmp++;
    if (csr_rdata !== 32'h100) begin
      n_bad++; $display("FAIL midreset_mtvec: got %h want %h", csr_rdata, 32'h100);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctl !== 20'h0) begin
      n_bad++; $display("FAIL midreset_no_redirect: got %h want %h", ctl, 20'h0);
    end
  endtask

  task automatic test_random();
    logic [11:0] addrs [7];
    logic [19:0] exp_ctl;
    logic [31:0] exp_info, exp_rd;
    apply_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      exp_ctl  = model_ctl();
      exp_info = {m_mip[15:0], m_mstatus[15:0]};
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_bad++; $display("FAIL rand_ctl[%0d]: got %h want %h", i, ctl, exp_ctl);
      end
      n_cmp++;
      if (csr_info !== exp_info) begin
        n_bad++; $display("FAIL rand_csr_info[%0d]: got %h want %h", i, csr_info, exp_info);
      end
      addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
      addrs[3] = 12'h342; addrs[4] = 12'h344; addrs[5] = 12'h301;
      addrs[6] = 12'($urandom_range(0, 4095));
      exception  = ($urandom_range(0, 5) == 0);
      excep_info = $urandom;
      irq_ext    = ($urandom_range(0, 9) == 0);
      uret       = ($urandom_range(0, 3) == 0);
      csr_we     = ($urandom_range(0, 2) == 0);
      csr_addr   = addrs[$urandom_range(0, 6)];
      csr_wdata  = $urandom;
      #1;
      exp_rd = model_rdata(csr_addr);
      n_cmp++;
      if (csr_rdata !== exp_rd) begin
        n_bad++; $display("FAIL rand_rdata[%0d] addr %h: got %h want %h", i, csr_addr, csr_rdata, exp_rd);
      end
      model_step(exception, excep_info, irq_ext, uret, csr_we, csr_addr, csr_wdata);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_return();
    test_interrupt();
    test_conflicts();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
